// File: rtl/dmem_stream_loader.sv
// ---------------------------------------------------------------------------
// dmem_stream_loader
//
// Preloads the datapath's data memory from a byte stream while the datapath
// is held in reset. Every three accepted bytes are packed little-endian into
// one DATA_WIDTH word and written at consecutive addresses starting at 0.
// Once LOAD_WORDS words have been written the datapath reset is released.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         one-cycle pulse that begins a load session (IDLE or DONE)
//   in_valid      byte present on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle (combinational, RECV only)
//   mem_we        data memory write strobe, one cycle per word
//   mem_addr      data memory write address
//   mem_wdata     data memory write data
//   cpu_rst       datapath reset, high until loading completes
//   busy          session in progress (RECV or WRITE)
//   done          load complete
//   fmt_error     sticky: unused high bits of a third byte were nonzero
//   word_count    words written this session
// ---------------------------------------------------------------------------
module dmem_stream_loader #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256,
  parameter int LOAD_WORDS    = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     fmt_error,
  output logic [ADDRESS_WIDTH:0]   word_count
);

  // Number of bits the third byte contributes to a word; the rest of that
  // byte must be zero or the stream is malformed.
  localparam int HIGH_BITS = DATA_WIDTH - 16;

  // Session length, kept inside 1..MEM_SIZE so a bad parameter can never
  // drive writes past the end of the memory.
  localparam int WORD_LIMIT = (LOAD_WORDS > MEM_SIZE) ? MEM_SIZE :
                              ((LOAD_WORDS < 1) ? 1 : LOAD_WORDS);
  localparam logic [ADDRESS_WIDTH:0] LAST_COUNT = (ADDRESS_WIDTH+1)'(WORD_LIMIT);

  // Bits of the third byte that fall outside the word.
  localparam logic [7:0] HIGH_MASK = 8'hFF << HIGH_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  byte_cnt;
  logic [15:0] asm_lo;
  logic        xfer;
  logic        last_word;

  // A byte moves only when both sides agree in the same cycle. last_word
  // tells the WRITE cycle whether this word finishes the session.
  always_comb begin
    xfer      = in_valid & in_ready;
    last_word = ((word_count + 1'b1) == LAST_COUNT);
  end

  // State register: rst forces IDLE from any state, including mid-word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start is honoured only in IDLE and DONE, so a pulse
  // during a session is ignored. WRITE always lasts exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RECV;
      RECV:    if (xfer && (byte_cnt == 2'd2)) next_state = WRITE;
      WRITE:   next_state = last_word ? DONE : RECV;
      DONE:    if (start) next_state = RECV;
      default: next_state = IDLE;
    endcase
  end

  // The only combinational output: the loader is ready exactly in RECV.
  always_comb begin
    in_ready = (state == RECV);
  end

  // Registered outputs and datapath. Status flags are registered from
  // next_state so they change on the same edge as the state itself; in
  // particular cpu_rst falls on the edge where done rises. The memory write
  // is launched on the edge that accepts the third byte, so mem_we is high
  // for the single WRITE cycle. On the last word mem_addr is held instead of
  // incremented so a full-depth load never wraps back to address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      asm_lo     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      fmt_error  <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we  <= 1'b0;
      busy    <= (next_state == RECV) || (next_state == WRITE);
      done    <= (next_state == DONE);
      cpu_rst <= (next_state != DONE);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            mem_addr   <= '0;
            word_count <= '0;
            byte_cnt   <= 2'd0;
            fmt_error  <= 1'b0;
          end
        end

        RECV: begin
          if (xfer) begin
            case (byte_cnt)
              2'd0: begin
                asm_lo[7:0] <= in_data;
                byte_cnt    <= 2'd1;
              end
              2'd1: begin
                asm_lo[15:8] <= in_data;
                byte_cnt     <= 2'd2;
              end
              default: begin
                mem_wdata <= {in_data[HIGH_BITS-1:0], asm_lo};
                mem_we    <= 1'b1;
                byte_cnt  <= 2'd0;
                if ((in_data & HIGH_MASK) != 8'd0) begin
                  fmt_error <= 1'b1;
                end
              end
            endcase
          end
        end

        WRITE: begin
          word_count <= word_count + 1'b1;
          if (!last_word) begin
            mem_addr <= mem_addr + 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_dmem_stream_loader
//
// Bench for dmem_stream_loader. Two instances share clock and reset: a short
// one (LOAD_WORDS=2) for handshake, packing, error and restart sequences,
// and a full-depth one (LOAD_WORDS=256). Expected writes are queued as each
// word is driven and popped by a per-instance write monitor.
// ---------------------------------------------------------------------------
module tb_dmem_stream_loader;

  localparam int DW = 20;
  localparam int AW = 8;

  typedef struct {
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    int            gap;
    logic [DW-1:0] exp_data;
    bit            exp_fmt;
  } word_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  logic          start_s, valid_s;
  logic [7:0]    data_s;
  logic          in_ready_s, mem_we_s, cpu_rst_s, busy_s, done_s, fmt_error_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;
  logic [AW:0]   word_count_s;

  logic          start_f, valid_f;
  logic [7:0]    data_f;
  logic          in_ready_f, mem_we_f, cpu_rst_f, busy_f, done_f, fmt_error_f;
  logic [AW-1:0] mem_addr_f;
  logic [DW-1:0] mem_wdata_f;
  logic [AW:0]   word_count_f;

  int            checks = 0;
  int            errors = 0;
  wr_t           q_s[$];
  wr_t           q_f[$];
  int            we_cnt_s = 0;
  int            we_cnt_f = 0;
  logic [AW-1:0] exp_addr_s = '0;
  logic [AW-1:0] exp_addr_f = '0;
  wr_t           mon_s;
  wr_t           mon_f;

  always #5 clk = ~clk;

  dmem_stream_loader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(256), .LOAD_WORDS(2)
  ) u_small (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(valid_s), .in_data(data_s),
    .in_ready(in_ready_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .cpu_rst(cpu_rst_s), .busy(busy_s), .done(done_s),
    .fmt_error(fmt_error_s), .word_count(word_count_s)
  );

  dmem_stream_loader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(256), .LOAD_WORDS(256)
  ) u_full (
    .clk(clk), .rst(rst), .start(start_f), .in_valid(valid_f), .in_data(data_f),
    .in_ready(in_ready_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f),
    .mem_wdata(mem_wdata_f), .cpu_rst(cpu_rst_f), .busy(busy_f), .done(done_f),
    .fmt_error(fmt_error_f), .word_count(word_count_f)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Write monitors sample mid-cycle, when mem_we and its address/data are stable.
  always @(negedge clk) begin
    if (mem_we_s === 1'b1) begin
      we_cnt_s++;
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL small unexpected write: addr=0x%0h data=0x%0h, required no write",
                 mem_addr_s, mem_wdata_s);
      end else begin
        mon_s = q_s.pop_front();
        checkOutput("small write addr", 32'(mem_addr_s), 32'(mon_s.addr));
        checkOutput("small write data", 32'(mem_wdata_s), 32'(mon_s.data));
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we_f === 1'b1) begin
      we_cnt_f++;
      if (q_f.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL full unexpected write: addr=0x%0h data=0x%0h, required no write",
                 mem_addr_f, mem_wdata_f);
      end else begin
        mon_f = q_f.pop_front();
        checkOutput("full write addr", 32'(mem_addr_f), 32'(mon_f.addr));
        checkOutput("full write data", 32'(mem_wdata_f), 32'(mon_f.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int g = 0; g < n; g++) tick();
  endtask

  task automatic set_in(input bit full, input logic v, input logic [7:0] d);
    if (full) begin
      valid_f = v;
      data_f  = d;
    end else begin
      valid_s = v;
      data_s  = d;
    end
  endtask

  function automatic logic rdy(input bit full);
    return full ? in_ready_f : in_ready_s;
  endfunction

  task automatic drive_start(input bit full);
    if (full) begin
      start_f    = 1'b1;
      exp_addr_f = '0;
      we_cnt_f   = 0;
    end else begin
      start_s    = 1'b1;
      exp_addr_s = '0;
      we_cnt_s   = 0;
    end
    tick();
    start_s = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic send_byte(input bit full, input logic [7:0] b);
    int n = 0;
    set_in(full, 1'b1, b);
    while (!rdy(full) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte handshake timeout: in_ready=0 for %0d cycles, required 1", n);
    end else begin
      tick();
    end
    set_in(full, 1'b0, 8'hA5);
  endtask

  task automatic applyStimulus(input bit full, input word_vec_t v);
    wr_t e;
    send_byte(full, v.b0);
    idle_cycles(v.gap);
    send_byte(full, v.b1);
    idle_cycles(v.gap);
    e.data = v.exp_data;
    if (full) begin
      e.addr = exp_addr_f;
      q_f.push_back(e);
      exp_addr_f = exp_addr_f + 1'b1;
    end else begin
      e.addr = exp_addr_s;
      q_s.push_back(e);
      exp_addr_s = exp_addr_s + 1'b1;
    end
    send_byte(full, v.b2);
  endtask

  task automatic wait_done(input bit full, input string name);
    int n = 0;
    while (!(full ? done_f : done_s) && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(full ? done_f : done_s), 32'd1);
  endtask

  word_vec_t vecs[4];
  word_vec_t mv0, mv1, fv;
  bit        sess_fmt;

  initial begin
    vecs[0] = '{8'h45, 8'h23, 8'h01, 0, 20'h12345, 1'b0};
    vecs[1] = '{8'hEF, 8'hBE, 8'h0A, 0, 20'hABEEF, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 3, 20'hFFFFF, 1'b1};
    vecs[3] = '{8'h10, 8'h32, 8'h04, 1, 20'h43210, 1'b0};
    mv0     = '{8'h33, 8'h44, 8'h05, 0, 20'h54433, 1'b0};
    mv1     = '{8'h66, 8'h77, 8'h08, 2, 20'h87766, 1'b0};

    rst = 1'b1;
    start_s = 1'b0; valid_s = 1'b0; data_s = 8'h00;
    start_f = 1'b0; valid_f = 1'b0; data_f = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset values.
    checkOutput("reset in_ready",   32'(in_ready_s),   32'd0);
    checkOutput("reset mem_we",     32'(mem_we_s),     32'd0);
    checkOutput("reset mem_addr",   32'(mem_addr_s),   32'd0);
    checkOutput("reset mem_wdata",  32'(mem_wdata_s),  32'd0);
    checkOutput("reset cpu_rst",    32'(cpu_rst_s),    32'd1);
    checkOutput("reset busy",       32'(busy_s),       32'd0);
    checkOutput("reset done",       32'(done_s),       32'd0);
    checkOutput("reset fmt_error",  32'(fmt_error_s),  32'd0);
    checkOutput("reset word_count", 32'(word_count_s), 32'd0);
    checkOutput("reset full cpu_rst", 32'(cpu_rst_f),  32'd1);

    // in_valid without start: nothing is accepted or written.
    set_in(1'b0, 1'b1, 8'h55);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("idle in_ready", 32'(in_ready_s), 32'd0);
      checkOutput("idle cpu_rst",  32'(cpu_rst_s),  32'd1);
      checkOutput("idle done",     32'(done_s),     32'd0);
    end
    set_in(1'b0, 1'b0, 8'h00);
    checkOutput("idle no writes", 32'(we_cnt_s), 32'd0);

    // Table: two sessions of two words (basic packing, then format error with stalls).
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        drive_start(1'b0);
        sess_fmt = 1'b0;
      end
      applyStimulus(1'b0, vecs[i]);
      sess_fmt = sess_fmt | vecs[i].exp_fmt;
      checkOutput("fmt_error sticky", 32'(fmt_error_s), 32'(sess_fmt));
      if (i % 2 == 1) begin
        wait_done(1'b0, "session done");
        checkOutput("session cpu_rst",    32'(cpu_rst_s),    32'd0);
        checkOutput("session busy",       32'(busy_s),       32'd0);
        checkOutput("session word_count", 32'(word_count_s), 32'd2);
        checkOutput("session fmt_error",  32'(fmt_error_s),  32'(sess_fmt));
        idle_cycles(3);
        checkOutput("session write count", 32'(we_cnt_s), 32'd2);
        checkOutput("session done held",   32'(done_s),   32'd1);
      end
    end

    // Restart from DONE (fmt_error is still set from the previous session).
    drive_start(1'b0);
    checkOutput("restart cpu_rst",    32'(cpu_rst_s),    32'd1);
    checkOutput("restart done",       32'(done_s),       32'd0);
    checkOutput("restart busy",       32'(busy_s),       32'd1);
    checkOutput("restart mem_addr",   32'(mem_addr_s),   32'd0);
    checkOutput("restart word_count", 32'(word_count_s), 32'd0);
    checkOutput("restart fmt_error",  32'(fmt_error_s),  32'd0);
    applyStimulus(1'b0, vecs[0]);
    applyStimulus(1'b0, vecs[1]);
    wait_done(1'b0, "restart done");
    checkOutput("restart word_count end", 32'(word_count_s), 32'd2);

    // Reset in the middle of a word: the stale bytes must never be written.
    drive_start(1'b0);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst mem_we",     32'(mem_we_s),     32'd0);
    checkOutput("midrst in_ready",   32'(in_ready_s),   32'd0);
    checkOutput("midrst cpu_rst",    32'(cpu_rst_s),    32'd1);
    checkOutput("midrst busy",       32'(busy_s),       32'd0);
    checkOutput("midrst word_count", 32'(word_count_s), 32'd0);
    drive_start(1'b0);
    applyStimulus(1'b0, mv0);
    applyStimulus(1'b0, mv1);
    wait_done(1'b0, "midrst done");
    idle_cycles(2);
    checkOutput("midrst write count", 32'(we_cnt_s), 32'd2);

    // Full depth: word i carries i, last write lands at address 255.
    drive_start(1'b1);
    for (int i = 0; i < 256; i++) begin
      fv.b0       = i[7:0];
      fv.b1       = 8'h00;
      fv.b2       = 8'h00;
      fv.gap      = 0;
      fv.exp_data = DW'(i);
      fv.exp_fmt  = 1'b0;
      applyStimulus(1'b1, fv);
    end
    wait_done(1'b1, "full done");
    checkOutput("full word_count", 32'(word_count_f), 32'd256);
    checkOutput("full cpu_rst",    32'(cpu_rst_f),    32'd0);
    checkOutput("full busy",       32'(busy_f),       32'd0);
    checkOutput("full fmt_error",  32'(fmt_error_f),  32'd0);
    idle_cycles(6);
    checkOutput("full write count",   32'(we_cnt_f),    32'd256);
    checkOutput("full queue drained", 32'(q_f.size()), 32'd0);
    checkOutput("full done held",     32'(done_f),      32'd1);
    checkOutput("small queue drained", 32'(q_s.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_stream_loader.md
Name: dmem_stream_loader

Overview:
- Upstream stage for the pipelined datapath. Runs while the datapath is held in reset and preloads its data memory.
- Accepts a byte stream over a valid/ready handshake and packs every 3 bytes into one DATA_WIDTH word, little-endian.
- Writes each packed word through a dedicated memory write port at consecutive addresses, starting at address 0.
- Releases the datapath reset once the programmed number of words has been written.

Parameters:
- DATA_WIDTH, 20: memory word width. The packing rules below are fixed for 17..24.
- ADDRESS_WIDTH, 8: data memory address width.
- MEM_SIZE, 256: data memory depth in words.
- LOAD_WORDS, 256: words to load per session. Legal range is 1..MEM_SIZE.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session.
- in_valid  in  1  a byte is present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  data memory write strobe, one cycle per word.
- mem_addr  out  ADDRESS_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- cpu_rst  out  1  reset to the datapath; high until loading completes.
- busy  out  1  session in progress (RECV or WRITE).
- done  out  1  load complete (DONE state).
- fmt_error  out  1  sticky: the unused high bits of a third byte were nonzero.
- word_count  out  ADDRESS_WIDTH+1  words written this session.

Behaviour:
- All outputs are registered except in_ready. in_ready is 1 exactly when state==RECV.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, fmt_error=0, word_count=0, state=IDLE, byte_cnt=0.
- A byte transfer occurs only on in_valid & in_ready in the same cycle. in_data is ignored otherwise.
- FSM states are IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_rst=1.
  - start -> RECV; clear mem_addr, word_count, byte_cnt and fmt_error.
- RECV:
  - Each transfer stores byte k (k = byte_cnt) into assembly bits [8k+7:8k].
  - Byte 0 and byte 1 increment byte_cnt.
  - Byte 2 contributes only its low DATA_WIDTH-16 bits. If its remaining high bits are nonzero, set fmt_error; the truncated word is still written.
  - On the byte-2 transfer, go to WRITE and reset byte_cnt to 0.
- WRITE (one cycle):
  - mem_we=1, mem_wdata = assembled word, mem_addr = current address.
  - Next cycle: mem_we=0, word_count+1, mem_addr+1.
  - If word_count+1 == LOAD_WORDS -> DONE, else -> RECV.
- Latency and throughput: the third byte is accepted at edge N, and mem_we is high in the cycle after N. The earliest next accepted byte is at edge N+2, giving 4 cycles per word at best.
- Address range: mem_addr never exceeds LOAD_WORDS-1. With LOAD_WORDS=MEM_SIZE=256 the last write goes to 255. mem_addr does not wrap into a second write at 0; it is held or cleared on entering DONE, and its value after DONE is don't-care. word_count reaches 256, which is why it is ADDRESS_WIDTH+1 bits wide.
- DONE:
  - cpu_rst=0 on the same edge done=1 rises; busy=0.
  - Holds until rst or start. A start pulse re-enters RECV with cpu_rst=1 again, mem_addr=0 and fmt_error cleared.
- start while busy is ignored.
- in_valid outside RECV is ignored, and no byte is consumed.
- rst at any time, including mid-word or in the WRITE cycle, returns all state to reset values. The partial word is discarded, and mem_we is 0 on the cycle after the rst edge.
- The stream source may drop in_valid between bytes for any number of cycles. Partial assembly is preserved across the gap.

Test Plan:
- Reset then idle (LOAD_WORDS=2): hold rst 2 cycles, drive in_valid=1 with no start -> in_ready=0, mem_we never 1, cpu_rst=1, done=0.
- Basic load (LOAD_WORDS=2): start, then bytes 0x45,0x23,0x01,0xEF,0xBE,0x0A back-to-back -> first write mem_addr=0, mem_wdata=0x12345; second write mem_addr=1, mem_wdata=0xABEEF. Exactly 2 mem_we pulses; done=1, cpu_rst=0, word_count=2, fmt_error=0.
- Format error and stalls: bytes 0xFF,0xFF,0xFF with in_valid gaps of 3 cycles -> mem_wdata=0xFFFFF, fmt_error=1 and stays 1 through DONE.
- Full depth (LOAD_WORDS=256): stream 768 bytes where word i encodes i -> last write at mem_addr=255 carries 0x000FF, no write to address 0 after it, word_count=256, done=1.
- Reset mid-word: start, send 0x11,0x22, assert rst one cycle, start, send 0x33,0x44,0x05,... -> first write mem_addr=0, data=0x54433. The stale bytes never appear.
- Restart after done: in DONE pulse start -> cpu_rst=1, done=0, busy=1 next cycle; new session writes again from mem_addr=0.
